// File: rtl/simon_input_checker.sv
// simon_input_checker: checks the player's button presses against the
// pattern shown by the flash stage and reports win / check_done to the
// message stage. Raw buttons are synchronised, debounced and edge-detected.
// Each press must arrive within a bounded time.
module simon_input_checker #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned TIMEOUT_CYCLES  = 500_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [2:0] bit_count,
    input  logic [7:0] bit_gen,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic [1:0] led_input,
    output logic [3:0] press_count,
    output logic       check_done,
    output logic       win
);

    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned TM_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TM_W-1:0] TM_LAST = TM_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0] PRESS_MAX = 4'd8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_PRESS,
        WAIT_RELEASE,
        DONE
    } state_t;

    // Bit 0 is the left button and bit 1 is the right button throughout.
    logic [1:0]      raw;
    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      deb;
    logic [1:0]      deb_d;
    logic [DB_W-1:0] db_cnt [2];
    logic [1:0]      press_ev;
    logic            left_ev;
    logic            right_ev;

    state_t          state;
    logic [2:0]      idx;
    logic [2:0]      cap_count;
    logic [7:0]      cap_pattern;
    logic [TM_W-1:0] timer;
    logic            expect_right;

    assign raw      = {btn_right, btn_left};
    assign press_ev = deb & ~deb_d;
    assign left_ev  = press_ev[0];
    assign right_ev = press_ev[1];

    // A pattern bit of 1 asks for the right button and 0 asks for the left.
    assign expect_right = cap_pattern[idx];

    // Synchronise both buttons, debounce them and keep the previous level for edge detection.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1     <= '0;
            sync2     <= '0;
            deb       <= '0;
            deb_d     <= '0;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_d <= deb;
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    deb[i]    <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Round control FSM with registered outputs; dropping enable aborts from any state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            cap_count   <= '0;
            cap_pattern <= '0;
            timer       <= '0;
            led_input   <= '0;
            press_count <= '0;
            check_done  <= 1'b0;
            win         <= 1'b0;
        end else if (state != IDLE && !enable) begin
            state       <= IDLE;
            idx         <= '0;
            timer       <= '0;
            led_input   <= '0;
            press_count <= '0;
            check_done  <= 1'b0;
            win         <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    led_input   <= '0;
                    press_count <= '0;
                    check_done  <= 1'b0;
                    win         <= 1'b0;
                    if (enable) begin
                        state       <= WAIT_PRESS;
                        idx         <= '0;
                        timer       <= '0;
                        cap_count   <= bit_count;
                        cap_pattern <= bit_gen;
                    end
                end

                WAIT_PRESS: begin
                    timer <= timer + TM_W'(1);
                    if (timer == TM_LAST) begin
                        state      <= DONE;
                        check_done <= 1'b1;
                        win        <= 1'b0;
                    end else if (left_ev && right_ev) begin
                        state      <= DONE;
                        check_done <= 1'b1;
                        win        <= 1'b0;
                    end else if (left_ev || right_ev) begin
                        led_input <= right_ev ? 2'b01 : 2'b10;
                        if (right_ev == expect_right) begin
                            state <= WAIT_RELEASE;
                            if (press_count != PRESS_MAX) begin
                                press_count <= press_count + 4'd1;
                            end
                        end else begin
                            state      <= DONE;
                            check_done <= 1'b1;
                            win        <= 1'b0;
                        end
                    end
                end

                WAIT_RELEASE: begin
                    if (deb == 2'b00) begin
                        if (idx == cap_count) begin
                            state      <= DONE;
                            check_done <= 1'b1;
                            win        <= 1'b1;
                        end else begin
                            state     <= WAIT_PRESS;
                            idx       <= idx + 3'd1;
                            timer     <= '0;
                            led_input <= '0;
                        end
                    end
                end

                DONE: begin
                    check_done <= 1'b1;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simon_input_checker.sv
// Self-checking bench for simon_input_checker: directed scenarios plus
// randomised rounds scored against a pattern-walking reference model.
module tb_simon_input_checker;

    localparam int unsigned DB = 4;
    localparam int unsigned TO = 200;
    localparam int LAT = DB + 3;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic [2:0] bit_count;
    logic [7:0] bit_gen;
    logic       btn_left;
    logic       btn_right;
    logic [1:0] led_input;
    logic [3:0] press_count;
    logic       check_done;
    logic       win;

    int n_assert = 0;
    int n_fail   = 0;

    simon_input_checker #(
        .DEBOUNCE_CYCLES(DB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .bit_count  (bit_count),
        .bit_gen    (bit_gen),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .led_input  (led_input),
        .press_count(press_count),
        .check_done (check_done),
        .win        (win)
    );

    always #5 clock = ~clock;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_led"}, 32'(led_input), 32'd0);
        chk({tag, "_pc"}, 32'(press_count), 32'd0);
        chk({tag, "_cd"}, 32'(check_done), 32'd0);
        chk({tag, "_win"}, 32'(win), 32'd0);
    endtask

    // b: 0 = left, 1 = right, 2 = both
    task automatic set_btn(input int b, input logic v);
        if (b == 0 || b == 2) btn_left = v;
        if (b == 1 || b == 2) btn_right = v;
    endtask

    // Start a round, then scramble the pattern inputs: the captured copy must be used.
    task automatic start_round(input logic [7:0] pat, input logic [2:0] cnt);
        bit_gen   = pat;
        bit_count = cnt;
        enable    = 1'b1;
        tick(1);
        bit_gen   = ~pat;
        bit_count = 3'($urandom);
    endtask

    task automatic end_round();
        enable = 1'b0;
        tick(1);
    endtask

    // Single-button press: the echo must appear exactly LAT clocks after the raw rise.
    task automatic press_timed(input string tag, input int b, input logic [1:0] exp_led,
                               input int hold, input int gap);
        set_btn(b, 1'b1);
        tick(LAT - 1);
        chk({tag, "_early"}, 32'(led_input), 32'd0);
        tick(1);
        chk({tag, "_echo"}, 32'(led_input), 32'(exp_led));
        tick(hold - LAT);
        set_btn(b, 1'b0);
        tick(gap);
    endtask

    initial begin
        logic [7:0] pat;
        logic [2:0] cnt;
        int         err;
        int         exp_pc;
        logic       exp_win;
        logic [1:0] exp_led;
        logic       stop;
        logic       b;
        int         hold;
        int         gap;

        reset     = 1'b1;
        enable    = 1'b0;
        bit_count = '0;
        bit_gen   = '0;
        btn_left  = 1'b0;
        btn_right = 1'b0;
        tick(2);
        chk_zero("reset");
        reset = 1'b0;
        tick(1);

        // Correct round: pattern 101, three presses right, left, right.
        pat = 8'b0000_0101;
        start_round(pat, 3'd2);
        for (int i = 0; i < 3; i++) begin
            b = pat[i];
            press_timed($sformatf("t1_p%0d", i), b ? 1 : 0, b ? 2'b01 : 2'b10, 20, 20);
            chk($sformatf("t1_pc%0d", i), 32'(press_count), 32'(i + 1));
            if (i < 2) chk($sformatf("t1_cd%0d", i), 32'(check_done), 32'd0);
        end
        chk("t1_win", 32'(win), 32'd1);
        chk("t1_cd", 32'(check_done), 32'd1);
        chk("t1_pc", 32'(press_count), 32'd3);
        end_round();
        chk_zero("t1_clear");

        // Wrong press: right (correct) then right (expected left).
        start_round(pat, 3'd2);
        press_timed("t2_p0", 1, 2'b01, 20, 20);
        press_timed("t2_p1", 1, 2'b01, 20, 20);
        chk("t2_cd", 32'(check_done), 32'd1);
        chk("t2_win", 32'(win), 32'd0);
        chk("t2_pc", 32'(press_count), 32'd1);
        chk("t2_led", 32'(led_input), 32'b01);
        end_round();

        // Timeout exactly TO clocks after entering WAIT_PRESS.
        start_round(pat, 3'd2);
        tick(TO - 1);
        chk("t3_cd_before", 32'(check_done), 32'd0);
        tick(1);
        chk("t3_cd", 32'(check_done), 32'd1);
        chk("t3_win", 32'(win), 32'd0);
        chk("t3_pc", 32'(press_count), 32'd0);
        end_round();

        // Bounce rejection: 3-cycle glitches on the left button, which is the expected one.
        start_round(8'b0000_0000, 3'd0);
        for (int i = 0; i < 3; i++) begin
            btn_left = 1'b1;
            tick(3);
            btn_left = 1'b0;
            tick(5);
        end
        tick(4);
        chk("t4_glitch_led", 32'(led_input), 32'd0);
        chk("t4_glitch_pc", 32'(press_count), 32'd0);
        chk("t4_glitch_cd", 32'(check_done), 32'd0);
        end_round();

        // Right button held across the enable rise must not count.
        btn_right = 1'b1;
        tick(10);
        start_round(8'b0000_0001, 3'd1);
        tick(20);
        chk("t4_held_led", 32'(led_input), 32'd0);
        chk("t4_held_pc", 32'(press_count), 32'd0);
        btn_right = 1'b0;
        tick(10);
        chk("t4_rel_pc", 32'(press_count), 32'd0);
        press_timed("t4_repress", 1, 2'b01, 12, 12);
        chk("t4_repress_pc", 32'(press_count), 32'd1);
        end_round();

        // Simultaneous press on both buttons.
        start_round(8'b0000_0001, 3'd2);
        set_btn(2, 1'b1);
        tick(LAT - 1);
        chk("t5_cd_early", 32'(check_done), 32'd0);
        tick(1);
        chk("t5_cd", 32'(check_done), 32'd1);
        chk("t5_win", 32'(win), 32'd0);
        chk("t5_pc", 32'(press_count), 32'd0);
        set_btn(2, 1'b0);
        tick(10);
        end_round();

        // Reset in WAIT_RELEASE, then abort mid-round via enable.
        start_round(8'b0000_1001, 3'd3);
        btn_right = 1'b1;
        tick(LAT);
        chk("t6_pc_pre", 32'(press_count), 32'd1);
        chk("t6_led_pre", 32'(led_input), 32'b01);
        reset     = 1'b1;
        btn_right = 1'b0;
        enable    = 1'b0;
        tick(1);
        chk_zero("t6_reset");
        reset = 1'b0;
        tick(10);
        start_round(8'b0000_1001, 3'd3);
        chk("t6_new_pc", 32'(press_count), 32'd0);
        press_timed("t6_p0", 1, 2'b01, 10, 10);
        chk("t6_mid_pc", 32'(press_count), 32'd1);
        end_round();
        chk_zero("t6_abort");
        start_round(8'b0000_1001, 3'd3);
        tick(1);
        chk("t6_restart_pc", 32'(press_count), 32'd0);
        chk("t6_restart_cd", 32'(check_done), 32'd0);
        end_round();

        // Randomised rounds: the first one is a full 8-press round for the saturation point.
        for (int r = 0; r < 12; r++) begin
            pat = 8'($urandom);
            if (r == 0) begin
                cnt = 3'd7;
                err = 99;
            end else begin
                cnt = 3'($urandom_range(0, 7));
                err = int'($urandom_range(0, 2 * int'(cnt) + 2));
            end
            exp_pc  = 0;
            exp_win = 1'b0;
            exp_led = 2'b00;
            stop    = 1'b0;
            start_round(pat, cnt);
            for (int i = 0; i <= int'(cnt); i++) begin
                if (!stop) begin
                    b    = (i == err) ? ~pat[i] : pat[i];
                    hold = int'($urandom_range(8, 16));
                    gap  = int'($urandom_range(8, 16));
                    press_timed($sformatf("r%0d_p%0d", r, i), b ? 1 : 0,
                                b ? 2'b01 : 2'b10, hold, gap);
                    if (b == pat[i]) begin
                        exp_pc++;
                        if (i == int'(cnt)) begin
                            exp_win = 1'b1;
                        end else begin
                            chk($sformatf("r%0d_mid_pc%0d", r, i), 32'(press_count), 32'(exp_pc));
                            chk($sformatf("r%0d_mid_led%0d", r, i), 32'(led_input), 32'd0);
                            chk($sformatf("r%0d_mid_cd%0d", r, i), 32'(check_done), 32'd0);
                        end
                    end else begin
                        exp_led = b ? 2'b01 : 2'b10;
                        stop    = 1'b1;
                    end
                end
            end
            chk($sformatf("r%0d_cd", r), 32'(check_done), 32'd1);
            chk($sformatf("r%0d_win", r), 32'(win), 32'(exp_win));
            chk($sformatf("r%0d_pc", r), 32'(press_count), 32'(exp_pc));
            if (!exp_win) chk($sformatf("r%0d_led", r), 32'(led_input), 32'(exp_led));
            end_round();
            chk_zero($sformatf("r%0d_clear", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/simon_input_checker.md
Name: simon_input_checker

Overview:
- Consumes the player's button presses after the flash-bits display stage has shown the pattern. Compares each press against the same pattern (bit_gen, bit_count) that drove the flash stage.
- Produces win and check_done, which feed the message-display stage's win and start inputs.
- Synchronises and debounces the raw buttons, echoes accepted presses on two LEDs, and enforces a per-press timeout.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles before a debounced level changes (10 ms at 100 MHz).
- TIMEOUT_CYCLES, 500_000_000: maximum cycles allowed in WAIT_PRESS before the round is lost (5 s at 100 MHz).

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  level; high = check a round (driven from flash stage display_done path); low = abort/clear
- bit_count  input  3  index of last pattern bit (round length = bit_count+1)
- bit_gen  input  8  pattern; bit=1 expects right button, bit=0 expects left button
- btn_left  input  1  raw asynchronous left button, active-high
- btn_right  input  1  raw asynchronous right button, active-high
- led_input  output  2  echo of accepted press: 2'b10 left, 2'b01 right, 2'b00 none
- press_count  output  4  number of correct presses accepted this round
- check_done  output  1  high while in DONE; drives message-stage start
- win  output  1  result, valid while check_done=1

Behaviour:
- One clock domain. Reset is synchronous, active-high, and overrides everything.
- Reset values: FSM=IDLE, led_input=00, press_count=0, check_done=0, win=0. Sync flops, debounced levels, debounce counters and timer are all 0.
- Input conditioning, per button:
  - 2-flop synchroniser feeds a debouncer.
  - Debouncer counter increments while the synced value differs from the debounced value, and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 with values still differing, the debounced value flips.
  - Press event = debounced rising edge (debounced & ~debounced_d).
  - Latency from first clock sampling raw high (held stable) to FSM reaction: DEBOUNCE_CYCLES+3 clocks.
- Pattern capture: on the IDLE->WAIT_PRESS transition, bit_count and bit_gen are registered. Changes afterwards are ignored until the next round.
- States:
  - IDLE: outputs cleared. enable=1 -> WAIT_PRESS with idx=0 and timer=0.
  - WAIT_PRESS: timer increments every cycle.
    - Timer reaches TIMEOUT_CYCLES-1 -> DONE, win=0.
    - Press events on both buttons in the same cycle -> DONE, win=0.
    - A single press event whose button matches bit_gen[idx] -> WAIT_RELEASE. On that transition led_input shows the button and press_count increments.
    - A single press event whose button does not match -> DONE, win=0, with led_input showing the wrong button.
  - WAIT_RELEASE: timer held.
    - Leave only when both debounced levels are 0.
    - If idx==bit_count -> DONE, win=1.
    - Otherwise idx+1, timer=0, led_input=00 -> WAIT_PRESS.
    - Press events in this state are ignored.
  - DONE: check_done=1; win and press_count are held. Stays until enable=0.
- enable=0 in any non-IDLE state -> IDLE on the next edge, with all outputs cleared on that edge. Same handling when aborted mid-round.
- A button already held when the round starts does not count. It must be released and re-pressed, because only edges count.
- press_count saturates at 8. bit_count=7 gives 8 presses. idx never exceeds the captured bit_count.
- Timer width is clog2(TIMEOUT_CYCLES). Debounce counter width is clog2(DEBOUNCE_CYCLES).

Test Plan:
Bench parameters for all scenarios: DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=200.
1. Correct round:
   - Stimulus: bit_gen=8'b0000_0101, bit_count=2, enable=1; presses right, left, right, each 20 cycles with 20-cycle gaps.
   - Required: win=1, check_done=1, press_count=3. Each led_input echo appears exactly 7 clocks after the raw rise.
2. Wrong press:
   - Stimulus: same pattern; presses right then right.
   - Required: second press gives DONE, win=0, press_count=1, led_input=01.
3. Timeout:
   - Stimulus: enable=1, no press.
   - Required: check_done=1, win=0 exactly 200 clocks after entering WAIT_PRESS.
4. Bounce rejection and held-at-start:
   - Stimulus: 3-cycle glitches on btn_left; then btn_right held across enable rise.
   - Required: no press events are accepted until btn_right is released and re-pressed.
5. Simultaneous press:
   - Stimulus: both buttons rise in the same cycle.
   - Required: DONE with win=0.
6. Reset and abort:
   - Stimulus: reset asserted mid-WAIT_RELEASE; separately, enable dropped mid-round.
   - Required: next edge shows all outputs 0 and FSM in IDLE. A new enable starts with press_count=0.
